// File: rtl/pipeline_drain_buffer_if.sv
// pipeline_drain_buffer_if
//   Bundles the credit, pipeline-capture and consumer handshake signals of
//   pipeline_drain_buffer.
//   slave  : the buffer itself.
//   master : the surrounding logic (upstream injector, pipeline output, consumer).
//   Signals:
//     upstream_push  one pulse per word injected at the pipeline input
//     credit_ok      upstream may inject this cycle
//     in_valid/in_data   word leaving the fixed-latency pipeline
//     out_valid/out_data/out_ready   FWFT consumer handshake
//     count          FIFO occupancy
//     overflow       sticky, word arrived with no space
//     proto_err      sticky, push without credit or word with nothing in flight
interface pipeline_drain_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  upstream_push;
  logic                  credit_ok;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  proto_err;

  modport slave (
    input  upstream_push, in_valid, in_data, out_ready,
    output credit_ok, out_valid, out_data, count, overflow, proto_err
  );

  modport master (
    output upstream_push, in_valid, in_data, out_ready,
    input  credit_ok, out_valid, out_data, count, overflow, proto_err
  );
endinterface

// File: rtl/pipeline_drain_buffer.sv
// pipeline_drain_buffer
//   Credit-managed FWFT FIFO placed after a non-stallable register pipeline.
//   Every word injected upstream reserves a slot (INFLIGHT) so that it always
//   finds space when it emerges, even if the consumer stalls.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  pipeline_drain_buffer_if.slave (credit, capture and consumer sides)
module pipeline_drain_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int NUM_STAGES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  pipeline_drain_buffer_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         inflight;
  logic                  overflow;
  logic                  proto_err;

  logic [CW:0] reserved;
  logic        credit_ok;
  logic        pop;
  logic        wr_en;
  logic        push_ok;
  logic        bad_push;
  logic        orphan;
  logic        inflight_dec;

  // Credit is decoded purely from registered occupancy and reservations.
  assign reserved  = {1'b0, count} + {1'b0, inflight};
  assign credit_ok = (reserved < LIMIT);

  assign pop      = (count != '0) && bus.out_ready;
  // A full FIFO can still absorb a word if the head leaves on the same edge.
  assign wr_en    = bus.in_valid && ((count != FULL) || pop);
  assign push_ok  = bus.upstream_push && credit_ok;
  assign bad_push = bus.upstream_push && !credit_ok;
  // A word with no outstanding reservation: flagged, and INFLIGHT must not wrap.
  assign orphan       = bus.in_valid && (inflight == '0);
  assign inflight_dec = bus.in_valid && !orphan;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      inflight  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;

      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({push_ok, inflight_dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (bus.in_valid && !wr_en) overflow <= 1'b1;
      if (bad_push || orphan)     proto_err <= 1'b1;
    end
  end

  assign bus.credit_ok = credit_ok;
  assign bus.out_valid = (count != '0);
  // Zero when empty so the output is clean straight out of reset.
  assign bus.out_data  = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.proto_err = proto_err;

`ifndef SYNTHESIS
  a_reserved_bound: assert property (@(posedge clk) disable iff (rst)
    reserved <= LIMIT);
  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    int'(inflight) <= NUM_STAGES);
`endif
endmodule

// File: tb/tb_pipeline_drain_buffer.sv
module tb_pipeline_drain_buffer;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int NS    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_drain_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifc ();

  pipeline_drain_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_STAGES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic          push    = 1'b0;
  logic          bad     = 1'b0;
  logic          ready   = 1'b0;
  logic          force_v = 1'b0;
  logic [DW-1:0] push_d  = '0;
  logic [DW-1:0] force_d = '0;

  // Upstream fixed-latency pipeline model: valid travels with data.
  logic          pv [NS];
  logic [DW-1:0] pd [NS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= push && !bad;
      pd[0] <= push_d;
      for (int i = 1; i < NS; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign ifc.upstream_push = push;
  assign ifc.out_ready     = ready;
  assign ifc.in_valid      = force_v | pv[NS-1];
  assign ifc.in_data       = force_v ? force_d : pd[NS-1];

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q [$];

  task automatic idle_inputs();
    push = 1'b0; bad = 1'b0; ready = 1'b0; force_v = 1'b0;
    push_d = '0; force_d = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
  endtask

  // Push on every cycle credit is offered, consumer stalled; ends at a negedge.
  task automatic fill_full(input logic [DW-1:0] base, output int acc);
    acc = 0;
    ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifc.credit_ok) begin
        push = 1'b1;
        push_d = base + DW'(acc);
        q.push_back(base + DW'(acc));
        acc++;
      end else begin
        push = 1'b0;
      end
    end
    @(negedge clk);
    push = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      push = 1'($urandom); ready = 1'($urandom); force_v = 1'($urandom);
      force_d = DW'($urandom); push_d = DW'($urandom);
    end
    #1;
    tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", ifc.out_valid); end
    tests++; if (ifc.count !== 5'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", ifc.count); end
    tests++; if (ifc.credit_ok !== 1'b1) begin fails++; $display("FAIL rst_credit: got %b want 1", ifc.credit_ok); end
    tests++; if (ifc.overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b want 0", ifc.overflow); end
    tests++; if (ifc.proto_err !== 1'b0) begin fails++; $display("FAIL rst_proto_err: got %b want 0", ifc.proto_err); end
    tests++; if (ifc.out_data !== 16'h0) begin fails++; $display("FAIL rst_out_data: got %h want 0000", ifc.out_data); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL post_rst_out_valid: got %b want 0", ifc.out_valid); end
    tests++; if (ifc.count !== 5'd0) begin fails++; $display("FAIL post_rst_count: got %0d want 0", ifc.count); end
    tests++; if (ifc.credit_ok !== 1'b1) begin fails++; $display("FAIL post_rst_credit: got %b want 1", ifc.credit_ok); end
    tests++; if (ifc.overflow !== 1'b0) begin fails++; $display("FAIL post_rst_overflow: got %b want 0", ifc.overflow); end
    tests++; if (ifc.proto_err !== 1'b0) begin fails++; $display("FAIL post_rst_proto_err: got %b want 0", ifc.proto_err); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] words [10];
    logic prev_iv;
    int idx;
    for (int i = 0; i < 10; i++) words[i] = DW'($urandom);
    prev_iv = 1'b0;
    idx = 0;
    ready = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      tests++; if (ifc.out_valid !== prev_iv) begin fails++; $display("FAIL stream_valid_latency cyc %0d: got %b want %b", cyc, ifc.out_valid, prev_iv); end
      if (prev_iv && idx < 10) begin
        tests++; if (ifc.out_data !== words[idx]) begin fails++; $display("FAIL stream_data[%0d]: got %h want %h", idx, ifc.out_data, words[idx]); end
        idx++;
      end
      tests++; if (ifc.count !== (prev_iv ? 5'd1 : 5'd0)) begin fails++; $display("FAIL stream_count cyc %0d: got %0d want %0d", cyc, ifc.count, prev_iv); end
      tests++; if (ifc.credit_ok !== 1'b1) begin fails++; $display("FAIL stream_credit cyc %0d: got %b want 1", cyc, ifc.credit_ok); end
      prev_iv = ifc.in_valid;
      push = (cyc < 10);
      push_d = (cyc < 10) ? words[cyc] : '0;
    end
    tests++; if (idx !== 10) begin fails++; $display("FAIL stream_word_count: got %0d want 10", idx); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int acc;
    logic [DW-1:0] exp;
    fill_full(16'h1000, acc);
    tests++; if (acc !== 16) begin fails++; $display("FAIL bp_accepted: got %0d want 16", acc); end
    tests++; if (ifc.credit_ok !== 1'b0) begin fails++; $display("FAIL bp_credit_low: got %b want 0", ifc.credit_ok); end
    tests++; if (ifc.count !== 5'd16) begin fails++; $display("FAIL bp_count: got %0d want 16", ifc.count); end
    tests++; if (dut.inflight !== 5'd0) begin fails++; $display("FAIL bp_inflight: got %0d want 0", dut.inflight); end
    tests++; if (ifc.overflow !== 1'b0) begin fails++; $display("FAIL bp_overflow: got %b want 0", ifc.overflow); end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = q.pop_front();
      tests++; if (ifc.out_valid !== 1'b1 || ifc.out_data !== exp) begin fails++; $display("FAIL bp_pop[%0d]: got %b/%h want 1/%h", i, ifc.out_valid, ifc.out_data, exp); end
      if (i == 1) begin
        tests++; if (ifc.credit_ok !== 1'b1) begin fails++; $display("FAIL bp_credit_return: got %b want 1", ifc.credit_ok); end
      end
      @(negedge clk);
    end
    tests++; if (ifc.count !== 5'd0 || ifc.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got count %0d valid %b want 0/0", ifc.count, ifc.out_valid); end
    idle_inputs();
  endtask

  task automatic test_full_steady();
    int acc;
    logic [DW-1:0] exp;
    fill_full(16'h2000, acc);
    tests++; if (ifc.count !== 5'd16) begin fails++; $display("FAIL full_fill_count: got %0d want 16", ifc.count); end
    // Words forced straight into the capture port with the consumer popping.
    for (int i = 0; i < 20; i++) begin
      tests++; if (ifc.count !== 5'd16 || ifc.overflow !== 1'b0) begin fails++; $display("FAIL full_steady_count[%0d]: got %0d/%b want 16/0", i, ifc.count, ifc.overflow); end
      tests++; if (ifc.out_data !== q[0]) begin fails++; $display("FAIL full_steady_head[%0d]: got %h want %h", i, ifc.out_data, q[0]); end
      push = ifc.credit_ok;
      push_d = 16'h0BAD;
      force_v = 1'b1;
      force_d = 16'h3000 + DW'(i);
      ready = 1'b1;
      void'(q.pop_front());
      q.push_back(16'h3000 + DW'(i));
      @(negedge clk);
    end
    force_v = 1'b0;
    push = 1'b0;
    tests++; if (ifc.count !== 5'd16 || ifc.overflow !== 1'b0) begin fails++; $display("FAIL full_steady_end: got %0d/%b want 16/0", ifc.count, ifc.overflow); end
    for (int i = 0; i < 16; i++) begin
      exp = q.pop_front();
      tests++; if (ifc.out_data !== exp) begin fails++; $display("FAIL full_wrap_order[%0d]: got %h want %h", i, ifc.out_data, exp); end
      @(negedge clk);
    end
    tests++; if (ifc.count !== 5'd0) begin fails++; $display("FAIL full_drain_count: got %0d want 0", ifc.count); end
    // The forced words had no reservation, so the protocol flag must be up.
    tests++; if (ifc.proto_err !== 1'b1) begin fails++; $display("FAIL full_orphan_proto: got %b want 1", ifc.proto_err); end
    do_reset();
  endtask

  task automatic test_error_flags();
    int acc;
    logic [DW-1:0] exp;
    fill_full(16'h4000, acc);
    tests++; if (ifc.credit_ok !== 1'b0 || ifc.proto_err !== 1'b0) begin fails++; $display("FAIL err_pre: got credit %b proto %b want 0/0", ifc.credit_ok, ifc.proto_err); end
    push = 1'b1; bad = 1'b1;
    @(negedge clk);
    push = 1'b0; bad = 1'b0;
    tests++; if (ifc.proto_err !== 1'b1) begin fails++; $display("FAIL err_proto_set: got %b want 1", ifc.proto_err); end
    tests++; if (dut.inflight !== 5'd0) begin fails++; $display("FAIL err_push_ignored: got inflight %0d want 0", dut.inflight); end
    repeat (3) @(negedge clk);
    tests++; if (ifc.proto_err !== 1'b1) begin fails++; $display("FAIL err_proto_sticky: got %b want 1", ifc.proto_err); end
    tests++; if (ifc.overflow !== 1'b0) begin fails++; $display("FAIL err_overflow_pre: got %b want 0", ifc.overflow); end
    force_v = 1'b1; force_d = 16'hBEEF; ready = 1'b0;
    @(negedge clk);
    force_v = 1'b0;
    tests++; if (ifc.overflow !== 1'b1) begin fails++; $display("FAIL err_overflow_set: got %b want 1", ifc.overflow); end
    tests++; if (ifc.count !== 5'd16) begin fails++; $display("FAIL err_overflow_count: got %0d want 16", ifc.count); end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = q.pop_front();
      tests++; if (ifc.out_data !== exp) begin fails++; $display("FAIL err_drain[%0d]: got %h want %h", i, ifc.out_data, exp); end
      @(negedge clk);
    end
    tests++; if (ifc.count !== 5'd0) begin fails++; $display("FAIL err_drain_count: got %0d want 0", ifc.count); end
    tests++; if (ifc.overflow !== 1'b1) begin fails++; $display("FAIL err_overflow_sticky: got %b want 1", ifc.overflow); end
    idle_inputs();
  endtask

  task automatic test_midstream_reset();
    ready = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      push = (n < 8);
      push_d = 16'h5000 + DW'(n);
    end
    push = 1'b0;
    tests++; if (ifc.count !== 5'd5) begin fails++; $display("FAIL mid_pre_count: got %0d want 5", ifc.count); end
    tests++; if (dut.inflight !== 5'd3) begin fails++; $display("FAIL mid_pre_inflight: got %0d want 3", dut.inflight); end
    #2 rst = 1'b1;
    #1;
    tests++; if (ifc.count !== 5'd0 || dut.inflight !== 5'd0) begin fails++; $display("FAIL mid_async_counters: got %0d/%0d want 0/0", ifc.count, dut.inflight); end
    tests++; if (ifc.out_valid !== 1'b0 || ifc.credit_ok !== 1'b1) begin fails++; $display("FAIL mid_async_outputs: got valid %b credit %b want 0/1", ifc.out_valid, ifc.credit_ok); end
    tests++; if (ifc.overflow !== 1'b0 || ifc.proto_err !== 1'b0) begin fails++; $display("FAIL mid_async_flags: got %b/%b want 0/0", ifc.overflow, ifc.proto_err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (ifc.count !== 5'd0 || ifc.credit_ok !== 1'b1 || ifc.proto_err !== 1'b0) begin fails++; $display("FAIL mid_post: got count %0d credit %b proto %b want 0/1/0", ifc.count, ifc.credit_ok, ifc.proto_err); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_steady();
    test_error_flags();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
